// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch constants,
// IF FSM state encoding and IF/ID bundle.
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'hF000_0000;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_KILL
  } if_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    inst:  NOP_INST,
    pc:    32'h0,
    valid: 1'b0
  };

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched word
// that could not enter IF/ID because ID was stalled.
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t q;

  // clear (or reset) empties the entry; load captures a word
  always_ff @(posedge clk) begin
    if (reset || clear) q <= BUBBLE;
    else if (load)      q <= din;
  end

  assign dout = q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives imem requests,
// handles stall/branch and feeds the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  output logic        ID_valid
);

  import cpu_pkg::*;

  if_state_e   state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] stale, stale_n;
  if_id_t      ifid, ifid_n;
  if_id_t      fetched;
  if_id_t      skid_q;
  logic        skid_load;
  logic        skid_clear;
  logic        take;
  logic [31:0] pc_inc;
  logic [31:0] br_tgt;

  assign take    = br_taken & ~stall;
  assign pc_inc  = pc + 32'(PC_STEP);
  assign br_tgt  = {16'h0, br_pc};
  assign fetched = '{
    inst:  imem_data,
    pc:    pc,
    valid: 1'b1
  };

  if_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (fetched),
    .dout  (skid_q)
  );

  // state, pc, stale address and IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      stale <= 32'h0;
      ifid  <= BUBBLE;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      stale <= stale_n;
      ifid  <= ifid_n;
    end
  end

  // next-state, memory request and IF/ID update
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    stale_n    = stale;
    ifid_n     = ifid;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    imem_req   = 1'b1;
    imem_addr  = pc;
    unique case (state)
      S_REQ: begin
        if (take) begin
          pc_n       = br_tgt;
          ifid_n     = BUBBLE;
          skid_clear = 1'b1;
          if (!imem_rdy) begin
            state_n = S_KILL;
            stale_n = pc;
          end
        end else if (imem_rdy) begin
          pc_n = pc_inc;
          if (stall) begin
            skid_load = 1'b1;
            state_n   = S_HOLD;
          end else begin
            ifid_n = fetched;
          end
        end else if (!stall) begin
          ifid_n = BUBBLE;
        end
      end
      S_HOLD: begin
        imem_req = 1'b0;
        if (!stall) begin
          skid_clear = 1'b1;
          state_n    = S_REQ;
          if (br_taken) begin
            pc_n   = br_tgt;
            ifid_n = BUBBLE;
          end else begin
            ifid_n = skid_q;
          end
        end
      end
      S_KILL: begin
        imem_addr = stale;
        if (take)     pc_n    = br_tgt;
        if (!stall)   ifid_n  = BUBBLE;
        if (imem_rdy) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  assign ID_inst  = ifid.inst;
  assign ID_pc    = ifid.pc;
  assign ID_valid = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a queue-based fetch model
// predicts IF/ID contents and imem requests every cycle.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'hF000_0000;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic [31:0] ID_inst;
  logic [31:0] ID_pc;
  logic        ID_valid;

  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  exp_t        sb[$];
  exp_t        held[$];
  exp_t        cur;
  logic [31:0] mpc;
  bit          stale;
  logic [31:0] stale_addr;
  bit          known = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_00C3;
  endfunction

  assign imem_data = mem(imem_addr);
  assign w_data    = mem(w_addr);

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdy  (imem_rdy),
    .imem_data (imem_data),
    .ID_inst   (ID_inst),
    .ID_pc     (ID_pc),
    .ID_valid  (ID_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk       (clk),
    .reset     (w_reset),
    .stall     (1'b0),
    .br_taken  (1'b0),
    .br_pc     (16'h0),
    .imem_req  (w_req),
    .imem_addr (w_addr),
    .imem_rdy  (1'b1),
    .imem_data (w_data),
    .ID_inst   (w_inst),
    .ID_pc     (w_pc),
    .ID_valid  (w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // one cycle: check request, drive inputs, advance model
  task automatic step(input bit r, input bit s, input bit b,
                      input logic [15:0] bp, input bit rd);
    bit   rdy_b;
    exp_t w;
    @(negedge clk);
    #1;
    if (known) begin
      chk("imem_req", {31'h0, imem_req}, {31'h0, held.size() == 0});
      if (held.size() == 0)
        chk("imem_addr", imem_addr, stale ? stale_addr : mpc);
    end
    rdy_b    = rd && (imem_req === 1'b1);
    reset    = r;
    stall    = s;
    br_taken = b;
    br_pc    = bp;
    imem_rdy = rdy_b;
    if (r) begin
      mpc   = 32'h0;
      stale = 0;
      held.delete();
      cur   = '{1'b0, NOP, 32'h0};
      known = 1;
    end else if (held.size() != 0) begin
      if (!s) begin
        if (b) begin
          mpc = {16'h0, bp};
          held.delete();
          cur = '{1'b0, NOP, 32'h0};
        end else begin
          cur = held.pop_front();
        end
      end
    end else if (stale) begin
      if (!s && b) mpc = {16'h0, bp};
      if (rdy_b) stale = 0;
    end else begin
      if (!s && b) begin
        if (!rdy_b) begin
          stale      = 1;
          stale_addr = mpc;
        end
        mpc = {16'h0, bp};
        cur = '{1'b0, NOP, 32'h0};
      end else if (rdy_b) begin
        w   = '{1'b1, mem(mpc), mpc};
        mpc = mpc + 32'd4;
        if (s) held.push_back(w);
        else   cur = w;
      end else if (!s) begin
        cur = '{1'b0, NOP, 32'h0};
      end
    end
    sb.push_back(cur);
  endtask

  // monitor: IF/ID after each edge against the model
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ID_valid", {31'h0, ID_valid}, {31'h0, e.valid});
        chk("ID_inst", ID_inst, e.inst);
        chk("ID_pc", ID_pc, e.pc);
      end
    end
  end

  // wrap-around instance: FFFF_FFFC then 0000_0000
  initial begin
    w_reset = 1'b1;
    repeat (2) @(negedge clk);
    w_reset = 1'b0;
    #1;
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    chk("wrap_id_pc0", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_id_pc1", w_pc, 32'h0000_0000);
    chk("wrap_valid", {31'h0, w_valid}, 32'h1);
  end

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    br_taken = 1'b0;
    br_pc    = 16'h0;
    imem_rdy = 1'b0;
    step(1, 0, 0, 16'h0, 1);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0040, 0);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 1, 1, 16'h0100, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(1, 1, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = (i < 1000) ? 90 : 50;
      step($urandom_range(99) == 0,
           $urandom_range(99) < 30,
           $urandom_range(99) < 10,
           16'($urandom_range(16'hFFFF)) & 16'hFFFC,
           $urandom_range(99) < rp);
    end
    repeat (3) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
